load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the memory stage and load_store_unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a single-port word memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses respond with resp_err instead of aligning down.
module load_store_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] datain,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] dataout
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t            state, state_nxt;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rdata_q;

  size_t             in_size, size_q;
  logic [ADDR_W+1:0] in_addr_aligned;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // 011/110/111 fall into the default and are handled as word accesses.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  always_comb begin
    in_size         = size_of(bus.req_funct3);
    size_q          = size_of(funct3_q);
    in_addr_aligned = bus.req_addr;
    if (in_size == SZ_H) in_addr_aligned[0]   = 1'b0;
    if (in_size == SZ_W) in_addr_aligned[1:0] = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  always_comb begin
    misalign = ((in_size == SZ_H) && bus.req_addr[0]) ||
               ((in_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
  end
`endif

  // Load extraction from the word arriving in WAIT.
  always_comb begin
    byte_v = dataout[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? dataout[31:16] : dataout[15:0];
    case (size_q)
      SZ_B:    load_ext = funct3_q[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    load_ext = funct3_q[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = dataout;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (size_q)
      SZ_B:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_H:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign)                                state_nxt = RESP;
          else if (bus.req_store && (in_size == SZ_W)) state_nxt = WR;
          else                                         state_nxt = RD;
`else
          if (bus.req_store && (in_size == SZ_W)) state_nxt = WR;
          else                                    state_nxt = RD;
`endif
        end
      end
      RD:      state_nxt = WAIT;
      WAIT:    state_nxt = store_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            addr_q   <= in_addr_aligned;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= misalign;
`endif
          end
        end
        WAIT: begin
          word_q <= dataout;
          if (!store_q) rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    bus.resp_err   = err_q;
`else
    bus.resp_err   = 1'b0;
`endif
    MemRead  = (state == RD);
    MemWrite = (state == WR);
    address  = addr_q[ADDR_W+1:2];
    datain   = merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural 32-word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  address;
  logic [31:0] datain;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] dataout;

  logic [31:0] mem [32];
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [4:0]  last_rd_addr, last_wr_addr;
  logic [31:0] last_wr_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  load_store_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .address  (address),
    .datain   (datain),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .dataout  (dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[address] <= datain;
      wr_cnt = wr_cnt + 1;
      last_wr_addr = address;
      last_wr_data = datain;
    end
    if (MemRead) begin
      dataout <= mem[address];
      rd_cnt = rd_cnt + 1;
      last_rd_addr = address;
    end
    if (MemRead && MemWrite) both_cnt = both_cnt + 1;
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [6:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total_cnt++;
    if (!bus.resp_valid) $display("FAIL resp_timeout a=%h resp_valid=%b want 1", a, bus.resp_valid);
    else pass_cnt++;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, MemRead, MemWrite} !== 5'b10000)
      $display("FAIL reset_ctrl got %b want 10000", {bus.req_ready, bus.resp_valid, bus.resp_err, MemRead, MemWrite});
    else pass_cnt++;
    total_cnt++;
    if ({address, datain, bus.resp_rdata} !== '0)
      $display("FAIL reset_data address=%h datain=%h rdata=%h want 0", address, datain, bus.resp_rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 7'h04, 32'h0000_0003, lat, rd, er);
    total_cnt++;
    if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++;
    if ({wr_cnt - w0, last_wr_addr, last_wr_data} !== {32'd1, 5'd1, 32'h3})
      $display("FAIL sw_write writes=%0d addr=%0d data=%h want 1/1/00000003", wr_cnt - w0, last_wr_addr, last_wr_data);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL sw_rdata got %h want 0", rd); else pass_cnt++;
    do_req(1'b1, 3'b010, 7'h08, 32'h1122_3344, lat, rd, er);
    do_req(1'b1, 3'b010, 7'h0C, 32'h8000_7FFF, lat, rd, er);
  endtask

  task automatic test_lw();
    int lat; logic [31:0] rd; logic er; int r0;
    r0 = rd_cnt;
    do_req(1'b0, 3'b010, 7'h04, 32'h0, lat, rd, er);
    total_cnt++;
    if (lat !== 3) $display("FAIL lw_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++;
    if ({rd_cnt - r0, last_rd_addr} !== {32'd1, 5'd1})
      $display("FAIL lw_read reads=%0d addr=%0d want 1/1", rd_cnt - r0, last_rd_addr);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0000_0003) $display("FAIL lw_rdata got %h want 00000003", rd); else pass_cnt++;
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 3'b000, 7'h09, 32'h0000_00AB, lat, rd, er);
    total_cnt++;
    if (lat !== 4) $display("FAIL sb_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++;
    if ({wr_cnt - w0, last_wr_addr, last_wr_data} !== {32'd1, 5'd2, 32'h1122_AB44})
      $display("FAIL sb_write writes=%0d addr=%0d data=%h want 1/2/1122ab44", wr_cnt - w0, last_wr_addr, last_wr_data);
    else pass_cnt++;
    do_req(1'b0, 3'b000, 7'h09, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hFFFF_FFAB) $display("FAIL lb_rdata got %h want ffffffab", rd); else pass_cnt++;
    do_req(1'b0, 3'b100, 7'h09, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h0000_00AB) $display("FAIL lbu_rdata got %h want 000000ab", rd); else pass_cnt++;
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 3'b001, 7'h0E, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'hFFFF_8000) $display("FAIL lh_rdata got %h want ffff8000", rd); else pass_cnt++;
    do_req(1'b0, 3'b101, 7'h0C, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h0000_7FFF) $display("FAIL lhu_rdata got %h want 00007fff", rd); else pass_cnt++;
    do_req(1'b0, 3'b011, 7'h0C, 32'h0, lat, rd, er);
    total_cnt++;
    if ({lat, rd} !== {32'd3, 32'h8000_7FFF})
      $display("FAIL f3_011_as_w lat=%0d rdata=%h want 3/80007fff", lat, rd);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int n; logic [31:0] held;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 7'h08;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_addr = 7'h04;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = bus.resp_rdata;
    total_cnt++;
    if (held !== 32'h1122_AB44) $display("FAIL stall_rdata got %h want 1122ab44", held); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_rdata} !== {1'b1, 1'b0, 32'h1122_AB44})
        $display("FAIL stall_hold cyc=%0d valid=%b ready=%b rdata=%h want 1/0/1122ab44", i, bus.resp_valid, bus.req_ready, bus.resp_rdata);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL stall_release valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
    else pass_cnt++;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 7'h08;
    bus.req_wdata  = 32'h0000_00CD;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.req_ready, MemWrite, MemRead, address} !== {1'b1, 1'b0, 1'b0, 5'd0})
      $display("FAIL midrst_state ready=%b wr=%b rd=%b addr=%0d want 1/0/0/0", bus.req_ready, MemWrite, MemRead, address);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if ({wr_cnt - w0, rd_cnt - r0} !== {32'd0, 32'd1})
      $display("FAIL midrst_strobes writes=%0d reads=%0d want 0/1", wr_cnt - w0, rd_cnt - r0);
    else pass_cnt++;
    do_req(1'b0, 3'b010, 7'h08, 32'h0, lat, rd, er);
    total_cnt++;
    if (rd !== 32'h1122_AB44) $display("FAIL midrst_word got %h want 1122ab44", rd); else pass_cnt++;
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(1'b0, 3'b010, 7'h06, 32'h0, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    total_cnt++;
    if ({er, rd, rd_cnt - r0, wr_cnt - w0, lat} !== {1'b1, 32'h0, 32'd0, 32'd0, 32'd1})
      $display("FAIL misalign_trap err=%b rdata=%h reads=%0d writes=%0d lat=%0d want 1/0/0/0/1", er, rd, rd_cnt - r0, wr_cnt - w0, lat);
    else pass_cnt++;
`else
    total_cnt++;
    if ({er, rd, rd_cnt - r0, last_rd_addr} !== {1'b0, 32'h3, 32'd1, 5'd1})
      $display("FAIL misalign_align err=%b rdata=%h reads=%0d addr=%0d want 0/00000003/1/1", er, rd, rd_cnt - r0, last_rd_addr);
    else pass_cnt++;
`endif
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_sw();
    test_lw();
    test_byte();
    test_half();
    test_stall();
    test_reset_mid();
    test_misalign();
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
